// File: rtl/spi_adc_rx.sv
// SPI master for CH parallel serial ADCs that share SCLK/CS. It reads FRAME-bit frames MSB-first and keeps the last DATA_W bits of each.
// Define SPI_ADC_OVERRUN_EN to add a sticky overrun flag (ports ovr_clr/overrun) for read edges dropped in single mode.
module spi_adc_rx #(
  parameter int DATA_W    = 12,
  parameter int LEAD_BITS = 4,
  parameter int CH        = 1,
  parameter int DIV       = 4,
  parameter int QUIET     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 single,
  input  logic                 read,
  output logic                 SPI_SCLK,
  output logic                 CS,
  input  logic [CH-1:0]        MISO,
  output logic [CH*DATA_W-1:0] audio,
  output logic                 new_data,
  output logic                 busy
`ifdef SPI_ADC_OVERRUN_EN
  ,
  input  logic                 ovr_clr,
  output logic                 overrun
`endif
);

  localparam int FRAME     = LEAD_BITS + DATA_W;
  localparam int QUIET_CYC = 2 * DIV * QUIET;
  localparam int CNT_W     = $clog2(QUIET_CYC + 2 * DIV + 1);
  localparam int BIT_W     = $clog2(FRAME + 1);

  localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(2 * DIV - 1);
  localparam logic [CNT_W-1:0] QUIET_LAST  = CNT_W'(QUIET_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(FRAME - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] QUIET_ST = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [CH*DATA_W-1:0]   shift_q, shift_d;
  logic [CH*DATA_W-1:0]   audio_q, audio_d;
  logic                   new_data_q, new_data_d;
  logic                   sclk_q, sclk_d;
  logic                   cs_q, cs_d;
  logic                   read_prev_q, read_prev_d;
  logic                   read_edge, req;

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    audio_d     = audio_q;
    new_data_d  = 1'b0;
    read_prev_d = read;
    read_edge   = read & ~read_prev_q;
    req         = single ? read_edge : read;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        // SCLK rises on the edge that ends the low half, so MISO is sampled on that same edge.
        if (cnt_q == HALF_LAST) begin
          for (int c = 0; c < CH; c++) begin
            shift_d[c*DATA_W +: DATA_W] = {shift_q[c*DATA_W +: DATA_W-1], MISO[c]};
          end
        end
        if (cnt_q == PERIOD_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d    = DONE;
            audio_d    = shift_q;
            new_data_d = 1'b1;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = QUIET_ST;
        cnt_d   = '0;
      end
      QUIET_ST: begin
        if (cnt_q == QUIET_LAST) state_d = IDLE;
        else                     cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // SCLK and CS are registered from next-state values so the pins stay glitch-free.
    cs_d   = !(state_d == START || state_d == SHIFT || state_d == DONE);
    sclk_d = !(state_d == SHIFT && cnt_d <= HALF_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      audio_q     <= '0;
      new_data_q  <= 1'b0;
      sclk_q      <= 1'b1;
      cs_q        <= 1'b1;
      read_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      audio_q     <= audio_d;
      new_data_q  <= new_data_d;
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      read_prev_q <= read_prev_d;
    end
  end

`ifdef SPI_ADC_OVERRUN_EN
  logic overrun_q, overrun_d;

  // A dropped edge sets the flag even when ovr_clr is asserted in the same cycle.
  always_comb begin
    overrun_d = overrun_q;
    if (ovr_clr) overrun_d = 1'b0;
    if (single && read_edge && state_q != IDLE) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`endif

  assign SPI_SCLK = sclk_q;
  assign CS       = cs_q;
  assign audio    = audio_q;
  assign new_data = new_data_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_adc_rx.sv
// Scoreboard bench for spi_adc_rx: a 2-channel default-timing instance and an 8-bit, DIV=1, no-lead-bit instance,
// each driven by a behavioural ADC that shifts its next bit out after every SCLK rise.
module tb_spi_adc_rx;

  typedef struct {
    logic [23:0] audio;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: CH=2, defaults otherwise (FRAME=16, DIV=4, QUIET=2)
  logic        single0, read0, sclk0, cs0, new_data0, busy0;
  logic [1:0]  miso0;
  logic [23:0] audio0;
  // Instance 1: DATA_W=8, LEAD_BITS=0, DIV=1
  logic        single1, read1, sclk1, cs1, new_data1, busy1;
  logic [0:0]  miso1;
  logic [7:0]  audio1;
`ifdef SPI_ADC_OVERRUN_EN
  logic ovr_clr0, overrun0, ovr_clr1, overrun1;
`endif

  spi_adc_rx #(.CH(2)) dut0 (
    .clk(clk), .rst(rst), .single(single0), .read(read0),
    .SPI_SCLK(sclk0), .CS(cs0), .MISO(miso0), .audio(audio0),
    .new_data(new_data0), .busy(busy0)
`ifdef SPI_ADC_OVERRUN_EN
    , .ovr_clr(ovr_clr0), .overrun(overrun0)
`endif
  );

  spi_adc_rx #(.DATA_W(8), .LEAD_BITS(0), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .single(single1), .read(read1),
    .SPI_SCLK(sclk1), .CS(cs1), .MISO(miso1), .audio(audio1),
    .new_data(new_data1), .busy(busy1)
`ifdef SPI_ADC_OVERRUN_EN
    , .ovr_clr(ovr_clr1), .overrun(overrun1)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  // ADC models: rise count resets while CS is high; the next MSB-first bit appears after each SCLK rise.
  logic [15:0] frm0 [2];
  logic [7:0]  frm1;
  int          rc0 = 0, rc1 = 0;
  logic        sclk0_prev = 1'b1, sclk1_prev = 1'b1;

  always @(negedge clk) begin
    if (cs0) rc0 = 0;
    else if (sclk0 && !sclk0_prev) rc0 = rc0 + 1;
    sclk0_prev = sclk0;
    for (int c = 0; c < 2; c++) miso0[c] = (rc0 < 16) ? frm0[c][15-rc0] : 1'b0;
    if (cs1) rc1 = 0;
    else if (sclk1 && !sclk1_prev) rc1 = rc1 + 1;
    sclk1_prev = sclk1;
    miso1[0] = (rc1 < 8) ? frm1[7-rc1] : 1'b0;
  end

  exp_t sb0[$];
  exp_t sb1[$];
  logic gap_en = 1'b0;
  logic gap_armed = 1'b0;
  int   cs_run = 0;

  always @(negedge clk) begin : mon0
    exp_t e;
    if (new_data0) begin
      if (sb0.size() == 0) check("nd0_unexpected", 1, 0);
      else begin
        e = sb0.pop_front();
        check("audio0", audio0, e.audio);
        check("nd0_cycle", cyc, e.cyc);
        check("sclk0_rises", rc0, 16);
      end
      if (gap_en) gap_armed = 1'b1;
    end
    if (!gap_en) gap_armed = 1'b0;
    if (cs0) cs_run = cs_run + 1;
    else begin
      if (gap_armed && cs_run > 0) check("cs0_gap", cs_run, 17);
      cs_run = 0;
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (new_data1) begin
      if (sb1.size() == 0) check("nd1_unexpected", 1, 0);
      else begin
        e = sb1.pop_front();
        check("audio1", {16'h0, audio1}, e.audio);
        check("nd1_cycle", cyc, e.cyc);
        check("sclk1_rises", rc1, 8);
      end
    end
  end

  task automatic wait_idle0(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy0 || new_data0) && n < budget);
    check("idle0_timeout", busy0, 0);
  endtask

  task automatic wait_idle1(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy1 && n < budget);
    check("idle1_timeout", busy1, 0);
  endtask

  // Pulse read0 for one cycle in single=sm mode and expect one frame.
  task automatic frame0(input logic sm, input logic [15:0] f0, input logic [15:0] f1);
    exp_t e;
    frm0[0] = f0;
    frm0[1] = f1;
    single0 = sm;
    read0   = 1'b1;
    e.audio = {f1[11:0], f0[11:0]};
    e.cyc   = cyc + 133;
    sb0.push_back(e);
    @(negedge clk);
    read0 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    rst = 1'b1;
    single0 = 1'b0; read0 = 1'b0; single1 = 1'b0; read1 = 1'b0;
    frm0[0] = '0; frm0[1] = '0; frm1 = '0;
`ifdef SPI_ADC_OVERRUN_EN
    ovr_clr0 = 1'b0; ovr_clr1 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cs0", cs0, 1);
    check("rst_sclk0", sclk0, 1);
    check("rst_busy0", busy0, 0);
    check("rst_nd0", new_data0, 0);
    check("rst_audio0", audio0, 0);
    check("rst_cs1", cs1, 1);
    check("rst_audio1", audio1, 0);

    // Basic frames, including nonzero leading bits that must be discarded.
    frame0(1'b0, 16'h0AC3, 16'h5F0E);
    wait_idle0(400);
    check("audio0_hold", audio0, 24'hF0EAC3);
    frame0(1'b0, 16'h0FFF, 16'h0001);
    wait_idle0(400);
    frame0(1'b0, 16'hF123, 16'hA000);
    wait_idle0(400);

    // read held high for 1000 cycles: back-to-back frames every 150 cycles.
    frm0[0] = 16'h0555;
    frm0[1] = 16'h3AAA;
    single0 = 1'b0;
    gap_en  = 1'b1;
    read0   = 1'b1;
    for (int k = 0; k < 7; k++) begin
      e.audio = 24'hAAA555;
      e.cyc   = cyc + 133 + 150 * k;
      sb0.push_back(e);
    end
    repeat (1000) @(negedge clk);
    read0 = 1'b0;
    wait_idle0(400);
    gap_en = 1'b0;
    check("sb0_after_burst", sb0.size(), 0);

    // single=1: a second edge 20 cycles in is dropped.
`ifdef SPI_ADC_OVERRUN_EN
    check("ovr0_before", overrun0, 0);
`endif
    frame0(1'b1, 16'h0123, 16'h0321);
    repeat (18) @(negedge clk);
    read0 = 1'b1;
    check("busy0_mid", busy0, 1);
    @(negedge clk);
    read0 = 1'b0;
    wait_idle0(400);
    repeat (20) @(negedge clk);
    check("busy0_no_second", busy0, 0);
`ifdef SPI_ADC_OVERRUN_EN
    check("ovr0_set", overrun0, 1);
    ovr_clr0 = 1'b1;
    @(negedge clk);
    ovr_clr0 = 1'b0;
    check("ovr0_clr", overrun0, 0);
`endif

    // Flip single mid-frame; the running frame still completes once.
    frame0(1'b0, 16'h0777, 16'h0888);
    repeat (50) @(negedge clk);
    single0 = 1'b1;
    wait_idle0(400);
    repeat (10) @(negedge clk);
    check("busy0_after_flip", busy0, 0);
    single0 = 1'b0;

    // Instance 1: 8-bit, no lead bits, DIV=1, new_data 18 cycles after accept.
    foreach (frm1[i]) frm1[i] = 1'b0;
    frm1    = 8'h5A;
    read1   = 1'b1;
    e.audio = 24'h00005A;
    e.cyc   = cyc + 18;
    sb1.push_back(e);
    @(negedge clk);
    read1 = 1'b0;
    wait_idle1(100);
    frm1    = 8'hC3;
    single1 = 1'b1;
    read1   = 1'b1;
    e.audio = 24'h0000C3;
    e.cyc   = cyc + 18;
    sb1.push_back(e);
    @(negedge clk);
    wait_idle1(100);
    repeat (10) @(negedge clk);
    read1 = 1'b0;
    check("busy1_held_single", busy1, 0);

    // Reset at SCLK rise 8 of a frame: no result, audio cleared.
    frm0[0] = 16'h0FFF;
    frm0[1] = 16'h0FFF;
    single0 = 1'b0;
    read0   = 1'b1;
    @(negedge clk);
    read0 = 1'b0;
    n = 0;
    while (rc0 < 8 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rise8_reached", rc0, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_cs0", cs0, 1);
    check("mid_rst_sclk0", sclk0, 1);
    check("mid_rst_busy0", busy0, 0);
    check("mid_rst_audio0", audio0, 0);
    check("mid_rst_audio1", audio1, 0);
    repeat (200) @(negedge clk);
    check("post_rst_audio0", audio0, 0);
    check("post_rst_busy0", busy0, 0);

    check("sb0_empty", sb0.size(), 0);
    check("sb1_empty", sb1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_adc_rx.md
SPI_ADC_RX -- requirements
Module: spi_adc_rx

Interface
REQ-001 SHALL have parameter DATA_W, default 12, meaning result bits per channel.
REQ-002 SHALL have parameter LEAD_BITS, default 4, meaning leading frame bits discarded; FRAME = LEAD_BITS+DATA_W.
REQ-003 SHALL have parameter CH, default 1, range 1..4, meaning parallel MISO channels sharing SCLK/CS.
REQ-004 SHALL have parameter DIV, default 4, minimum 1, meaning clk cycles per SCLK half-period.
REQ-005 SHALL have parameter QUIET, default 2, minimum 1, meaning SCLK periods CS held high after each frame.
REQ-006 SHALL have port clk  in  1  system clock, sole clock domain.
REQ-007 SHALL have port rst  in  1  synchronous active-high reset.
REQ-008 SHALL have port single  in  1  mode: 1 = one frame per read rising edge, 0 = frames while read high.
REQ-009 SHALL have port read  in  1  conversion request.
REQ-010 SHALL have port SPI_SCLK  out  1  serial clock, idle high.
REQ-011 SHALL have port CS  out  1  chip select, active low.
REQ-012 SHALL have port MISO  in  CH  serial data, bit c from channel c.
REQ-013 SHALL have port audio  out  CH*DATA_W  results, channel c at [c*DATA_W +: DATA_W].
REQ-014 SHALL have port new_data  out  1  one-cycle pulse when audio updates.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-016 SHALL implement states IDLE, START, SHIFT, DONE, QUIET.
REQ-017 IDLE: CS=1, SCLK=1; goes to START when a request is present (single=0: read=1; single=1: read 0->1 edge detected vs previous-cycle register).
REQ-018 START: CS=0, SCLK=1 for DIV cycles, then SHIFT.
REQ-019 SHIFT: FRAME bit periods of 2*DIV cycles each, SCLK low first DIV cycles, high last DIV cycles.
REQ-020 SHALL sample all MISO bits on the clk edge on which SCLK goes 0->1, shifting MSB-first into per-channel registers.
REQ-021 After the FRAME-th rising SCLK edge, SHALL hold SCLK high and enter DONE.
REQ-022 DONE (1 cycle): load audio with the last DATA_W bits of each channel (LEAD_BITS discarded), pulse new_data, go to QUIET.
REQ-023 QUIET: CS=1, SCLK=1 for 2*DIV*QUIET cycles, then IDLE; requests are not accepted in QUIET.
REQ-024 new_data SHALL be high exactly 1+DIV+2*DIV*FRAME cycles after the IDLE cycle accepting the request (133 at defaults).
REQ-025 audio SHALL hold its value between DONE states.
REQ-026 single=1: read edges arriving while busy SHALL be dropped, not queued.
REQ-027 single=0 with read held high: frames SHALL repeat back-to-back, separated only by QUIET plus one IDLE cycle.
REQ-028 Changing single mid-frame SHALL not affect the current frame; it applies at the next IDLE evaluation.

Reset
REQ-029 rst=1 SHALL, at the next clk edge and from any state, force IDLE, CS=1, SCLK=1, audio=0, new_data=0, busy=0, shift registers=0, edge register=0.
REQ-030 A frame interrupted by reset SHALL produce no new_data and leave audio=0.

Configuration
REQ-031 Macro SPI_ADC_OVERRUN_EN defined: ports ovr_clr (in, 1) and overrun (out, 1) SHALL exist; overrun is set sticky when a single=1 read edge is dropped, cleared by ovr_clr or rst; set wins over simultaneous ovr_clr.
REQ-032 Macro SPI_ADC_OVERRUN_EN undefined: ports ovr_clr and overrun and their logic SHALL be absent; all other behaviour unchanged.

Verification
REQ-033 Defaults, single=0, read pulse 1 cycle, MISO frame 0000_1010_1100_0011 -> exactly 16 SCLK rises, audio=12'hAC3, new_data once at cycle 133.
REQ-034 CH=2, MISO[0]=16'h0FFF, MISO[1]=16'h0001 -> audio={12'h001,12'hFFF}, single new_data pulse.
REQ-035 single=0, read held high 1000 cycles, DIV=4, QUIET=2 -> new_data period 133+16+1=150 cycles, CS high 17 cycles between frames.
REQ-036 single=1, read rising edge, second edge 20 cycles later -> one frame only; with SPI_ADC_OVERRUN_EN overrun=1 until ovr_clr.
REQ-037 rst asserted at SCLK rise 8 of a frame -> next cycle CS=1, SCLK=1, busy=0, audio=0, no new_data pulse.
REQ-038 LEAD_BITS=0, DATA_W=8, DIV=1, MISO=8'h5A -> audio=8'h5A, new_data at cycle 1+1+16=18.
